// File: rtl/rot_sequencer.sv
// rot_sequencer: sequencing controller for the accelerometer frame-rotation
// datapath (sin/cos table RAM + encoder feeding the linear-transform core).
//
// It serialises host table writes against rotations, so the table never
// changes while the core is busy. It hands one registered sample at a time to
// the core and returns the X/Y/Z results on a valid/ready output.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_req/ref/addr/data, cfg_ack
//                       host table write (entry or reference word) + ack pulse
//   s_valid/s_ready, s_acx/acy/acz, s_theta
//                       raw sample input handshake
//   rot_acx/acy/acz, rot_theta, rot_enable, rot_busy, rot_xac/yac/zac
//                       rotation core interface
//   tbl_w, tbl_w_ref, tbl_addr, tbl_data
//                       core table-write port
//   m_valid/m_ready, m_x/m_y/m_z
//                       result output handshake
//   table_ready         table loaded and consistent (set by a reference write)
//   err_timeout         sticky busy-watchdog error
//
// Optional build macro SEQ_STATS_EN adds:
//   stat_samples  (16b, wrapping count of delivered results)
//   stat_timeouts (8b, saturating count of watchdog expiries)
module rot_sequencer #(
  parameter int unsigned TIMEOUT_W    = 8,
  parameter int unsigned BUSY_TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic        cfg_ref,
  input  logic [7:0]  cfg_addr,
  input  logic [31:0] cfg_data,
  output logic        cfg_ack,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_acx,
  input  logic [15:0] s_acy,
  input  logic [15:0] s_acz,
  input  logic [31:0] s_theta,
  output logic [15:0] rot_acx,
  output logic [15:0] rot_acy,
  output logic [15:0] rot_acz,
  output logic [31:0] rot_theta,
  output logic        rot_enable,
  input  logic        rot_busy,
  input  logic [31:0] rot_xac,
  input  logic [31:0] rot_yac,
  input  logic [31:0] rot_zac,
  output logic        tbl_w,
  output logic        tbl_w_ref,
  output logic [7:0]  tbl_addr,
  output logic [31:0] tbl_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_x,
  output logic [31:0] m_y,
  output logic [31:0] m_z,
  output logic        table_ready,
  output logic        err_timeout
`ifdef SEQ_STATS_EN
  ,
  output logic [15:0] stat_samples,
  output logic [7:0]  stat_timeouts
`endif
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CFG     = 3'd1;
  localparam logic [2:0] START   = 3'd2;
  localparam logic [2:0] WAIT_HI = 3'd3;
  localparam logic [2:0] WAIT_LO = 3'd4;
  localparam logic [2:0] OUT     = 3'd5;

  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(BUSY_TIMEOUT - 1);

  logic [2:0]           state;
  logic                 cfg_is_ref;
  logic [TIMEOUT_W-1:0] wdog;
  logic                 waiting;
  logic                 timeout_fire;
  logic                 handshake;

  // Strobes decode straight from the state register: each lives in exactly
  // one single-cycle state, so they are one-cycle pulses and mutually
  // exclusive (cfg_ack intentionally accompanies the table strobe).
  assign cfg_ack    = (state == CFG);
  assign tbl_w      = (state == CFG) & ~cfg_is_ref;
  assign tbl_w_ref  = (state == CFG) & cfg_is_ref;
  assign rot_enable = (state == START);
  assign m_valid    = (state == OUT);
  assign s_ready    = (state == IDLE) & table_ready & ~cfg_req;

  // Still waiting on the core: busy not yet high in WAIT_HI, or still high in
  // WAIT_LO. The watchdog expires on the BUSY_TIMEOUT-th such cycle.
  assign waiting      = ((state == WAIT_HI) & ~rot_busy) |
                        ((state == WAIT_LO) &  rot_busy);
  assign timeout_fire = waiting & (wdog == WDOG_LAST);
  assign handshake    = (state == OUT) & m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cfg_is_ref  <= 1'b0;
      wdog        <= '0;
      tbl_addr    <= '0;
      tbl_data    <= '0;
      rot_acx     <= '0;
      rot_acy     <= '0;
      rot_acz     <= '0;
      rot_theta   <= '0;
      m_x         <= '0;
      m_y         <= '0;
      m_z         <= '0;
      table_ready <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_req) begin
            tbl_addr   <= cfg_addr;
            tbl_data   <= cfg_data;
            cfg_is_ref <= cfg_ref;
            state      <= CFG;
          end else if (s_valid && table_ready) begin
            rot_acx   <= s_acx;
            rot_acy   <= s_acy;
            rot_acz   <= s_acz;
            rot_theta <= s_theta;
            state     <= START;
          end
        end
        CFG: begin
          // Reference write completes a table load; any entry write
          // invalidates it until the reference is written again.
          table_ready <= cfg_is_ref;
          state       <= IDLE;
        end
        START: begin
          wdog  <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (rot_busy) begin
            wdog  <= '0;
            state <= WAIT_LO;
          end else if (timeout_fire) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wdog <= wdog + TIMEOUT_W'(1);
          end
        end
        WAIT_LO: begin
          if (!rot_busy) begin
            m_x   <= rot_xac;
            m_y   <= rot_yac;
            m_z   <= rot_zac;
            state <= OUT;
          end else if (timeout_fire) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wdog <= wdog + TIMEOUT_W'(1);
          end
        end
        OUT: begin
          if (m_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_samples  <= '0;
      stat_timeouts <= '0;
    end else begin
      if (handshake) stat_samples <= stat_samples + 16'd1;
      if (timeout_fire && (stat_timeouts != '1)) stat_timeouts <= stat_timeouts + 8'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = handshake;
`endif

endmodule

// File: tb/tb_rot_sequencer.sv
// Directed testbench for rot_sequencer (default build, SEQ_STATS_EN undefined).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rot_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_req = 1'b0, cfg_ref = 1'b0;
  logic [7:0]  cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic        cfg_ack;
  logic        s_valid = 1'b0, s_ready;
  logic [15:0] s_acx = '0, s_acy = '0, s_acz = '0;
  logic [31:0] s_theta = '0;
  logic [15:0] rot_acx, rot_acy, rot_acz;
  logic [31:0] rot_theta;
  logic        rot_enable;
  logic        rot_busy = 1'b0;
  logic [31:0] rot_xac = '0, rot_yac = '0, rot_zac = '0;
  logic        tbl_w, tbl_w_ref;
  logic [7:0]  tbl_addr;
  logic [31:0] tbl_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_x, m_y, m_z;
  logic        table_ready, err_timeout;

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rot_sequencer #(.TIMEOUT_W(8), .BUSY_TIMEOUT(200)) dut (
    .clk(clk), .rst(rst),
    .cfg_req(cfg_req), .cfg_ref(cfg_ref), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ack(cfg_ack),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_acx(s_acx), .s_acy(s_acy), .s_acz(s_acz), .s_theta(s_theta),
    .rot_acx(rot_acx), .rot_acy(rot_acy), .rot_acz(rot_acz), .rot_theta(rot_theta),
    .rot_enable(rot_enable), .rot_busy(rot_busy),
    .rot_xac(rot_xac), .rot_yac(rot_yac), .rot_zac(rot_zac),
    .tbl_w(tbl_w), .tbl_w_ref(tbl_w_ref), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .m_z(m_z),
    .table_ready(table_ready), .err_timeout(err_timeout)
  );

  // Core model: on rot_enable raise busy for busy_len cycles (0 = never).
  int busy_len = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      rot_busy = 1'b0;
      busy_cnt = 0;
    end else if (rot_enable) begin
      if (busy_len > 0) begin
        rot_busy = 1'b1;
        busy_cnt = busy_len - 1;
      end
    end else if (rot_busy) begin
      if (busy_cnt == 0) rot_busy = 1'b0;
      else busy_cnt = busy_cnt - 1;
    end
  end

  // Pulse counters and overlap detector.
  int ack_cnt = 0, ref_cnt = 0, en_cnt = 0, overlap_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      ack_cnt = ack_cnt + int'(cfg_ack);
      ref_cnt = ref_cnt + int'(tbl_w_ref);
      en_cnt  = en_cnt + int'(rot_enable);
      if ((int'(rot_enable) + int'(tbl_w) + int'(tbl_w_ref)) > 1) overlap_cnt = overlap_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic r, input logic [7:0] a, input logic [31:0] d,
                           input logic exp_ready);
    logic got;
    cfg_req  = 1'b1;
    cfg_ref  = r;
    cfg_addr = a;
    cfg_data = d;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (cfg_ack) got = 1'b1;
    end
    chk("cfg_ack_seen", 64'(got), 64'(1));
    if (got) begin
      chk("cfg_tbl_w", 64'(tbl_w), 64'(!r));
      chk("cfg_tbl_w_ref", 64'(tbl_w_ref), 64'(r));
      chk("cfg_tbl_data_lo", 64'(tbl_data[15:0]), 64'(d[15:0]));
      if (!r) begin
        chk("cfg_tbl_addr", 64'(tbl_addr), 64'(a));
        chk("cfg_tbl_data", 64'(tbl_data), 64'(d));
      end
    end
    cfg_req = 1'b0;
    @(negedge clk);
    chk("cfg_ack_single", 64'(cfg_ack), 64'(0));
    chk("cfg_table_ready", 64'(table_ready), 64'(exp_ready));
  endtask

  task automatic wait_mvalid(input int limit, output int n);
    n = 0;
    while (!m_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic take_result();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    chk("m_valid_drop", 64'(m_valid), 64'(0));
  endtask

  initial begin
    int n, acks0, refs0, e0;
    logic mv_seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cfg_ack", 64'(cfg_ack), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_table_ready", 64'(table_ready), 64'(0));
    chk("rst_err", 64'(err_timeout), 64'(0));
    chk("rst_tbl_data", 64'(tbl_data), 64'(0));
    chk("rst_rot_theta", 64'(rot_theta), 64'(0));

    // Sample offered with no table loaded: never accepted.
    s_valid = 1'b1; s_acx = 16'h0001; s_theta = 32'h5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("notbl_s_ready", 64'(s_ready), 64'(0));
    end
    chk("notbl_enable_cnt", 64'(en_cnt), 64'(0));
    s_valid = 1'b0;

    // Table load: one entry, then the reference word.
    cfg_write(1'b0, 8'h05, 32'h12340567, 1'b0);
    cfg_write(1'b1, 8'h00, 32'h00000100, 1'b1);
    @(negedge clk);
    chk("load_ack_cnt", 64'(ack_cnt), 64'(2));

    // Sample with a 10-cycle busy core.
    busy_len = 10;
    rot_xac = 32'hAAAA0001; rot_yac = 32'hBBBB0002; rot_zac = 32'hCCCC0003;
    s_valid = 1'b1; s_acx = 16'h0010; s_acy = 16'h0; s_acz = 16'h0; s_theta = 32'h20;
    #1 chk("s_ready_idle", 64'(s_ready), 64'(1));
    @(negedge clk);
    s_valid = 1'b0;
    chk("s1_enable", 64'(rot_enable), 64'(1));
    chk("s1_rot_acx", 64'(rot_acx), 64'(16'h0010));
    chk("s1_rot_theta", 64'(rot_theta), 64'(32'h20));
    wait_mvalid(50, n);
    chk("s1_latency", 64'(n), 64'(11));
    chk("s1_m_x", 64'(m_x), 64'(32'hAAAA0001));
    chk("s1_m_y", 64'(m_y), 64'(32'hBBBB0002));
    chk("s1_m_z", 64'(m_z), 64'(32'hCCCC0003));
    chk("s1_enable_cnt", 64'(en_cnt), 64'(1));
    rot_xac = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s1_hold_valid", 64'(m_valid), 64'(1));
      chk("s1_hold_m_x", 64'(m_x), 64'(32'hAAAA0001));
    end
    take_result();

    // cfg_req raised during WAIT_LO is deferred until the result is taken.
    busy_len = 6;
    rot_xac = 32'h11112222; rot_yac = 32'h0; rot_zac = 32'h0;
    s_valid = 1'b1; s_acx = 16'h0020; s_theta = 32'h40;
    @(negedge clk);
    s_valid = 1'b0;
    chk("s2_enable", 64'(rot_enable), 64'(1));
    repeat (2) @(negedge clk);
    cfg_req = 1'b1; cfg_ref = 1'b1; cfg_addr = 8'h00; cfg_data = 32'h00000100;
    acks0 = ack_cnt;
    refs0 = ref_cnt;
    wait_mvalid(50, n);
    chk("s2_latency", 64'(n), 64'(5));
    chk("s2_m_x", 64'(m_x), 64'(32'h11112222));
    rot_xac = 32'h0;
    repeat (2) @(negedge clk);
    chk("s2_no_ack", 64'(ack_cnt), 64'(acks0));
    chk("s2_no_ref", 64'(ref_cnt), 64'(refs0));
    chk("s2_hold_m_x", 64'(m_x), 64'(32'h11112222));
    take_result();
    chk("s2_idle_ack", 64'(cfg_ack), 64'(0));
    chk("s2_idle_s_ready", 64'(s_ready), 64'(0));
    @(negedge clk);
    chk("s2_late_ack", 64'(cfg_ack), 64'(1));
    chk("s2_late_ref", 64'(tbl_w_ref), 64'(1));
    chk("s2_late_data", 64'(tbl_data[15:0]), 64'(16'h0100));
    cfg_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("s2_ack_once", 64'(ack_cnt), 64'(acks0 + 1));
    chk("s2_table_ready", 64'(table_ready), 64'(1));

    // Core never raises busy: watchdog expiry.
    busy_len = 0;
    rot_xac = 32'h00005555;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk("to_enable", 64'(rot_enable), 64'(1));
    n = 0;
    mv_seen = 1'b0;
    while (!err_timeout && n < 300) begin
      @(negedge clk);
      n++;
      if (m_valid) mv_seen = 1'b1;
    end
    chk("to_cycles", 64'(n), 64'(201));
    chk("to_err", 64'(err_timeout), 64'(1));
    chk("to_no_m_valid", 64'(mv_seen), 64'(0));
    chk("to_m_x_kept", 64'(m_x), 64'(32'h11112222));
    chk("to_idle_s_ready", 64'(s_ready), 64'(1));
    busy_len = 3;
    rot_xac = 32'h33334444;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    chk("to_next_enable", 64'(rot_enable), 64'(1));
    wait_mvalid(50, n);
    chk("to_next_m_x", 64'(m_x), 64'(32'h33334444));
    chk("to_err_sticky", 64'(err_timeout), 64'(1));
    take_result();

    // Simultaneous cfg_req and s_valid: configuration wins.
    cfg_req = 1'b1; cfg_ref = 1'b0; cfg_addr = 8'h07; cfg_data = 32'hDEADBEEF;
    s_valid = 1'b1;
    #1 chk("both_s_ready", 64'(s_ready), 64'(0));
    @(negedge clk);
    chk("both_ack", 64'(cfg_ack), 64'(1));
    chk("both_tbl_w", 64'(tbl_w), 64'(1));
    chk("both_no_enable", 64'(rot_enable), 64'(0));
    chk("both_tbl_addr", 64'(tbl_addr), 64'(8'h07));
    cfg_req = 1'b0;
    @(negedge clk);
    chk("both_table_cleared", 64'(table_ready), 64'(0));
    e0 = en_cnt;
    repeat (3) @(negedge clk);
    chk("both_held_s_ready", 64'(s_ready), 64'(0));
    chk("both_held_enable", 64'(en_cnt), 64'(e0));
    busy_len = 2;
    rot_xac = 32'h77778888;
    cfg_write(1'b1, 8'h00, 32'h00000100, 1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    chk("reload_enable", 64'(rot_enable), 64'(1));
    wait_mvalid(50, n);
    chk("reload_m_x", 64'(m_x), 64'(32'h77778888));
    take_result();

    chk("pulse_overlap", 64'(overlap_cnt), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
